// File: rtl/mem_access.sv
// MEM-stage data memory access controller: issues one request per load/store,
// stalls the pipeline until the memory answers, and latches into a sticky error on faults.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        MemRead_in,
    input  logic        MemWrt_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] MemRead_out,
    output logic        mem_stall,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StWait, StDone, StErr} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] data_q, data_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic        mem_op, legal, req, stall;

    assign mem_op = valid_in & (MemRead_in | MemWrt_in);
    assign legal  = ~addr_in[0] & ~(MemRead_in & MemWrt_in);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        req     = 1'b0;
        stall   = 1'b0;
        err     = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem_op) begin
                    stall = 1'b1;
                    if (legal) begin
                        req     = 1'b1;
                        addr_d  = addr_in;
                        wdata_d = wdata_in;
                        wr_d    = MemWrt_in;
                        cnt_d   = 4'd0;
                        state_d = StWait;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StWait: begin
                stall = 1'b1;
                if (mem_done) begin
                    if (!wr_q) begin
                        data_d = mem_rdata;
                    end
                    state_d = StDone;
                end else if (cnt_q == 4'd15) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StErr: begin
                stall = 1'b1;
                err   = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The request is combinational in the issue cycle, so gate it with reset to drop it at once.
    assign mem_en      = req & ~rst;
    assign mem_stall   = stall & ~rst;
    assign mem_wr      = mem_en ? MemWrt_in : wr_q;
    assign mem_addr    = mem_en ? addr_in : addr_q;
    assign mem_wdata   = mem_en ? wdata_in : wdata_q;
    assign MemRead_out = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            data_q  <= 16'h0000;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: random load/store/nop traffic against a memory
// responder, followed by directed fault, timeout and reset scenarios.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, MemRead_in, MemWrt_in;
    logic [15:0] addr_in, wdata_in, mem_rdata;
    logic        mem_done;
    logic        mem_en, mem_wr, mem_stall, err;
    logic [15:0] mem_addr, mem_wdata, MemRead_out;

    mem_access dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .MemRead_in (MemRead_in),
        .MemWrt_in  (MemWrt_in),
        .addr_in    (addr_in),
        .wdata_in   (wdata_in),
        .mem_rdata  (mem_rdata),
        .mem_done   (mem_done),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .MemRead_out(MemRead_out),
        .mem_stall  (mem_stall),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] data;
        int          lat;
    } exp_t;

    typedef struct {
        int          delay;
        logic [15:0] rdata;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    tests  = 0;
    int    errors = 0;
    bit    mon_en   = 1'b0;
    bit    auto_mem = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_mem_wr"}, mem_wr, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_MemRead_out"}, MemRead_out, 0);
        check({tag, "_mem_stall"}, mem_stall, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic apply_reset();
        valid_in   = 1'b0;
        MemRead_in = 1'b0;
        MemWrt_in  = 1'b0;
        mem_done   = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        valid_in   = 1'b1;
        MemRead_in = rd;
        MemWrt_in  = wr;
        addr_in    = a;
        wdata_in   = d;
    endtask

    // Memory model: answers each request after the planned number of extra cycles.
    initial begin
        plan_t p;
        forever begin
            @(negedge clk);
            if (auto_mem && mem_en) begin
                if (plan_q.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL mem_plan_empty: request with no planned response (t=%0t)", $time);
                end else begin
                    p = plan_q.pop_front();
                    @(posedge clk);
                    repeat (p.delay) @(posedge clk);
                    #1;
                    mem_rdata = p.rdata;
                    mem_done  = 1'b1;
                    @(posedge clk);
                    #1;
                    mem_done  = 1'b0;
                    mem_rdata = 16'($urandom);
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each request and checks the completing DONE cycle.
    initial begin
        exp_t cur;
        bit   pending = 1'b0;
        int   lat = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mem_en) begin
                    check("req_while_busy", pending, 0);
                    if (exp_q.size() == 0) begin
                        tests++;
                        errors++;
                        $display("FAIL unexpected_req: mem_en=1, expected no request (t=%0t)", $time);
                    end else begin
                        cur = exp_q.pop_front();
                        check("req_wr", mem_wr, cur.wr);
                        check("req_addr", mem_addr, cur.addr);
                        if (cur.wr) check("req_wdata", mem_wdata, cur.wdata);
                        check("req_stall", mem_stall, 1);
                        pending = 1'b1;
                        lat     = 0;
                    end
                end else if (pending) begin
                    lat++;
                    if (mem_stall) begin
                        check("hold_addr", mem_addr, cur.addr);
                        check("hold_wr", mem_wr, cur.wr);
                        if (lat > 40) begin
                            check("done_reached", lat, cur.lat);
                            pending = 1'b0;
                        end
                    end else begin
                        check("done_data", MemRead_out, cur.data);
                        check("done_latency", lat, cur.lat);
                        check("done_err", err, 0);
                        pending = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_data;
        logic [15:0] a, d, rd;
        int          kind, dly, cyc;
        logic        s;

        rst = 1'b1;
        valid_in = 1'b1; MemRead_in = 1'b1; MemWrt_in = 1'b0;
        addr_in = 16'h0010; wdata_in = 16'h0; mem_rdata = 16'h0; mem_done = 1'b0;
        #1;
        // A legal load is presented while reset is held: nothing may be issued.
        check_reset_outputs("reset");
        @(posedge clk);
        apply_reset();

        // Random traffic.
        exp_data = 16'h0000;
        mon_en   = 1'b1;
        auto_mem = 1'b1;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            a    = 16'($urandom) & 16'hFFFE;
            d    = 16'($urandom);
            if (kind == 0) begin
                valid_in   = $urandom_range(0, 1);
                MemRead_in = valid_in ? 1'b0 : 1'($urandom);
                MemWrt_in  = valid_in ? 1'b0 : 1'($urandom);
                addr_in    = 16'($urandom);
                wdata_in   = d;
            end else begin
                dly = $urandom_range(0, 5);
                rd  = 16'($urandom);
                plan_q.push_back('{delay: dly, rdata: rd});
                if (kind == 1) exp_data = rd;
                exp_q.push_back('{wr: (kind == 2), addr: a, wdata: d, data: exp_data,
                                  lat: dly + 2});
                issue(kind == 1, kind == 2, a, d);
            end
            cyc = 0;
            do begin
                @(negedge clk);
                s = mem_stall;
                if (kind == 0) check("nop_stall", s, 0);
                @(posedge clk);
                cyc++;
            end while (s && cyc < 50);
            if (s) check("advance_timeout", s, 0);
            #1;
        end
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        mon_en   = 1'b0;
        auto_mem = 1'b0;
        apply_reset();

        // Load, answer two cycles after the request.
        issue(1, 0, 16'h0010, 16'h0);
        @(negedge clk);
        check("ld_en", mem_en, 1);
        check("ld_wr", mem_wr, 0);
        check("ld_addr", mem_addr, 16'h0010);
        check("ld_stall_req", mem_stall, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("ld_en_wait", mem_en, 0);
        check("ld_stall_w1", mem_stall, 1);
        @(posedge clk); #1;
        mem_done = 1'b1; mem_rdata = 16'hBEEF;
        @(negedge clk);
        check("ld_stall_w2", mem_stall, 1);
        @(posedge clk); #1;
        mem_done = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        check("ld_done_stall", mem_stall, 0);
        check("ld_done_data", MemRead_out, 16'hBEEF);
        @(posedge clk); #1;

        // Store answered the next cycle: load data must be untouched.
        issue(0, 1, 16'h0020, 16'h1234);
        @(negedge clk);
        check("st_en", mem_en, 1);
        check("st_wr", mem_wr, 1);
        check("st_addr", mem_addr, 16'h0020);
        check("st_wdata", mem_wdata, 16'h1234);
        @(posedge clk); #1;
        mem_done = 1'b1; mem_rdata = 16'h5555;
        @(posedge clk); #1;
        mem_done = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        check("st_done_stall", mem_stall, 0);
        check("st_data_kept", MemRead_out, 16'hBEEF);
        @(posedge clk); #1;

        // Timeout: 16 WAIT cycles with no answer, then ERR.
        issue(1, 0, 16'h0100, 16'h0);
        @(posedge clk); #1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check($sformatf("to_wait%0d", i), {err, mem_stall}, 2'b01);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("to_err", err, 1);
        check("to_stall", mem_stall, 1);
        @(posedge clk); #1;
        apply_reset();

        // Answer on the 16th WAIT cycle wins over the timeout.
        issue(1, 0, 16'h0200, 16'h0);
        @(posedge clk);
        repeat (15) @(posedge clk);
        #1;
        mem_done = 1'b1; mem_rdata = 16'hA5A5;
        @(posedge clk); #1;
        mem_done = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        check("late_done_stall", mem_stall, 0);
        check("late_done_err", err, 0);
        check("late_done_data", MemRead_out, 16'hA5A5);
        @(posedge clk); #1;
        apply_reset();

        // Misaligned load, then read+write together: both fault without a request.
        issue(1, 0, 16'h0011, 16'h0);
        @(negedge clk);
        check("mis_no_en", mem_en, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mis_err", err, 1);
        repeat (3) @(posedge clk);
        #1 valid_in = 1'b0;
        @(negedge clk);
        check("mis_stall_held", mem_stall, 1);
        check("mis_err_held", err, 1);
        @(posedge clk); #1;
        apply_reset();
        issue(1, 1, 16'h0040, 16'h0);
        @(negedge clk);
        check("both_no_en", mem_en, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("both_err", err, 1);
        @(posedge clk); #1;
        apply_reset();

        // Reset mid-WAIT, then a stray answer.
        issue(1, 0, 16'h0300, 16'h0);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_wait_en", mem_en, 0);
        check("rst_wait_stall", mem_stall, 0);
        valid_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_done = 1'b1; mem_rdata = 16'hFFFF;
        @(posedge clk); #1;
        mem_done = 1'b0;
        @(negedge clk);
        check_reset_outputs("stray");
        @(posedge clk); #1;
        issue(1, 0, 16'h0400, 16'h0);
        @(negedge clk);
        check("stray_idle_en", mem_en, 1);
        @(posedge clk); #1;
        valid_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
